msrv32_wb_stage: RTL and testbench

//  Execute-to-writeback stage directly downstream of the ALU. It registers the ALU result_out

---
 rtl/msrv32_wb_stage.sv | 135 +++++++++++++
 tb/tb_msrv32_wb_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_wb_stage.sv
// rtl/msrv32_wb_stage.sv - execute-to-writeback stage: source select, load wait/align, regfile write port
// Registers the result with rd controls, waits on data memory for loads and drives the register file write.
module msrv32_wb_stage #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        ex_valid_in,
  output logic        ex_ready_out,
  input  logic        flush_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] csr_data_in,
  input  logic [2:0]  wb_sel_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        rf_we_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        rf_we_out,
  output logic [4:0]  rf_rd_addr_out,
  output logic [31:0] rf_wr_data_out,
  output logic        load_busy_out,
  output logic        load_err_out
);

  typedef enum logic {RUN, LOAD_WAIT} state_t;

  state_t      state;
  logic        discard;
  logic [7:0]  cnt;
  logic [4:0]  ld_rd;
  logic        ld_we;
  logic [1:0]  ld_size;
  logic        ld_uns;
  logic [1:0]  ld_off;

  logic        handshake;
  logic        rvalid_live;
  logic        timeout;
  logic [31:0] sel_data;
  logic [31:0] shifted;
  logic [15:0] half_v;
  logic [31:0] load_data;

  assign ex_ready_out  = (state == RUN);
  assign load_busy_out = (state == LOAD_WAIT);
  assign handshake     = ex_valid_in & ex_ready_out;
  // An rvalid seen while discard is set answers an abandoned load and is never used.
  assign rvalid_live   = dmem_rvalid_in & ~discard;
  assign timeout       = (state == LOAD_WAIT) & ~flush_in & ~rvalid_live &
                         (cnt == 8'(LOAD_TIMEOUT));
  assign load_err_out  = timeout;

  always_comb begin
    sel_data = 32'h0;
    case (wb_sel_in)
      3'b000:  sel_data = alu_result_in;
      3'b010:  sel_data = pc_plus4_in;
      3'b011:  sel_data = imm_in;
      3'b100:  sel_data = csr_data_in;
      default: sel_data = 32'h0;
    endcase
  end

  assign shifted = dmem_rdata_in >> {ld_off, 3'b000};
  assign half_v  = ld_off[1] ? dmem_rdata_in[31:16] : dmem_rdata_in[15:0];

  always_comb begin
    load_data = dmem_rdata_in;
    case (ld_size)
      2'b00:   load_data = {{24{~ld_uns & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~ld_uns & half_v[15]}}, half_v};
      default: load_data = dmem_rdata_in;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state          <= RUN;
      rf_we_out      <= 1'b0;
      rf_rd_addr_out <= 5'd0;
      rf_wr_data_out <= 32'h0;
      discard        <= 1'b0;
      cnt            <= 8'd0;
      ld_rd          <= 5'd0;
      ld_we          <= 1'b0;
      ld_size        <= 2'b00;
      ld_uns         <= 1'b0;
      ld_off         <= 2'b00;
    end else begin
      rf_we_out <= 1'b0;
      if (dmem_rvalid_in && discard)
        discard <= 1'b0;
      case (state)
        RUN: begin
          if (handshake && !flush_in) begin
            if (wb_sel_in == 3'b001) begin
              ld_rd   <= rd_addr_in;
              ld_we   <= rf_we_in;
              ld_size <= load_size_in;
              ld_uns  <= load_unsigned_in;
              ld_off  <= alu_result_in[1:0];
              cnt     <= 8'd1;
              state   <= LOAD_WAIT;
            end else begin
              rf_we_out      <= rf_we_in & (rd_addr_in != 5'd0);
              rf_rd_addr_out <= rd_addr_in;
              rf_wr_data_out <= sel_data;
            end
          end
        end
        LOAD_WAIT: begin
          cnt <= cnt + 8'd1;
          if (flush_in) begin
            state   <= RUN;
            discard <= ~rvalid_live;
          end else if (rvalid_live) begin
            rf_we_out      <= ld_we & (ld_rd != 5'd0);
            rf_rd_addr_out <= ld_rd;
            rf_wr_data_out <= load_data;
            state          <= RUN;
          end else if (timeout) begin
            discard <= 1'b1;
            state   <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_msrv32_wb_stage.sv
// tb/tb_msrv32_wb_stage.sv - directed self-checking bench for msrv32_wb_stage
// Drives inputs 1ns after the rising edge and samples outputs at the same point.
module tb_msrv32_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_ready, flush;
  logic [31:0] alu_result, pc_plus4, imm, csr_data;
  logic [2:0]  wb_sel;
  logic [4:0]  rd_addr;
  logic        rf_we_i;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wr_data;
  logic        load_busy, load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msrv32_wb_stage #(.LOAD_TIMEOUT(4)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .ex_valid_in           (ex_valid),
    .ex_ready_out          (ex_ready),
    .flush_in              (flush),
    .alu_result_in         (alu_result),
    .pc_plus4_in           (pc_plus4),
    .imm_in                (imm),
    .csr_data_in           (csr_data),
    .wb_sel_in             (wb_sel),
    .rd_addr_in            (rd_addr),
    .rf_we_in              (rf_we_i),
    .load_size_in          (load_size),
    .load_unsigned_in      (load_unsigned),
    .dmem_rvalid_in        (dmem_rvalid),
    .dmem_rdata_in         (dmem_rdata),
    .rf_we_out             (rf_we),
    .rf_rd_addr_out        (rf_rd_addr),
    .rf_wr_data_out        (rf_wr_data),
    .load_busy_out         (load_busy),
    .load_err_out          (load_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [4:0] rd);
    ex_valid = 1'b1; wb_sel = 3'b001; alu_result = addr; load_size = size;
    load_unsigned = uns; rd_addr = rd; rf_we_i = 1'b1;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({ex_ready, rf_we, rf_rd_addr, rf_wr_data, load_busy, load_err} !== {1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: ready=%b we=%b addr=%0d data=%h busy=%b err=%b, expected ready=1 rest 0",
               ex_ready, rf_we, rf_rd_addr, rf_wr_data, load_busy, load_err);
    end
  endtask

  task automatic test_alu();
    logic [2:0]  sels [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b111};
    logic [31:0] exps [5] = '{32'h7, 32'h104, 32'hFFFF_F800, 32'h0000_0300, 32'h0};
    alu_result = 32'h7; pc_plus4 = 32'h104; imm = 32'hFFFF_F800; csr_data = 32'h0000_0300;
    rf_we_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1'b1; wb_sel = sels[i]; rd_addr = 5'(5 + i);
      tick();
      checks++;
      if ({rf_we, rf_rd_addr, rf_wr_data} !== {1'b1, 5'(5 + i), exps[i]}) begin
        errors++;
        $display("FAIL alu_sel%0d: we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                 sels[i], rf_we, rf_rd_addr, rf_wr_data, 5 + i, exps[i]);
      end
    end
    ex_valid = 1'b0;
    tick();
    checks++;
    if ({rf_we, rf_rd_addr, rf_wr_data} !== {1'b0, 5'd9, 32'h0}) begin
      errors++;
      $display("FAIL alu_idle_hold: we=%b addr=%0d data=%h, expected we=0 addr=9 data=0",
               rf_we, rf_rd_addr, rf_wr_data);
    end
  endtask

  task automatic test_load_byte();
    issue_load(32'h0000_1003, 2'b00, 1'b0, 5'd7);
    checks++;
    if ({rf_we, load_busy, ex_ready} !== 3'b010) begin
      errors++;
      $display("FAIL lb_wait: we=%b busy=%b ready=%b, expected 0 1 0", rf_we, load_busy, ex_ready);
    end
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_FF11;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, rf_rd_addr, rf_wr_data, ex_ready, load_busy} !== {1'b1, 5'd7, 32'hFFFF_FF80, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL lb_data: we=%b addr=%0d data=%h ready=%b busy=%b, expected 1 7 ffffff80 1 0",
               rf_we, rf_rd_addr, rf_wr_data, ex_ready, load_busy);
    end
  endtask

  task automatic test_load_half_word();
    issue_load(32'h0000_2002, 2'b01, 1'b1, 5'd8);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, rf_rd_addr, rf_wr_data} !== {1'b1, 5'd8, 32'h0000_BEEF}) begin
      errors++;
      $display("FAIL lhu: we=%b addr=%0d data=%h, expected 1 8 0000beef", rf_we, rf_rd_addr, rf_wr_data);
    end
    issue_load(32'h0000_3001, 2'b10, 1'b0, 5'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, rf_rd_addr, rf_wr_data} !== {1'b0, 5'd0, 32'h1234_5678}) begin
      errors++;
      $display("FAIL lw_x0: we=%b addr=%0d data=%h, expected 0 0 12345678", rf_we, rf_rd_addr, rf_wr_data);
    end
  endtask

  task automatic test_flush_load();
    issue_load(32'h0000_4000, 2'b10, 1'b0, 5'd9);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({rf_we, ex_ready, load_busy} !== 3'b010) begin
      errors++;
      $display("FAIL flush_load_run: we=%b ready=%b busy=%b, expected 0 1 0", rf_we, ex_ready, load_busy);
    end
    tick();
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if (rf_we !== 1'b0 || rf_wr_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL flush_late_rvalid: we=%b data=%h, expected we=0 data=12345678", rf_we, rf_wr_data);
    end
    ex_valid = 1'b1; wb_sel = 3'b000; alu_result = 32'h55; rd_addr = 5'd3; rf_we_i = 1'b1;
    tick();
    ex_valid = 1'b0;
    checks++;
    if ({rf_we, rf_rd_addr, rf_wr_data} !== {1'b1, 5'd3, 32'h55}) begin
      errors++;
      $display("FAIL flush_then_add: we=%b addr=%0d data=%h, expected 1 3 55", rf_we, rf_rd_addr, rf_wr_data);
    end
  endtask

  task automatic test_timeout();
    issue_load(32'h0000_5000, 2'b10, 1'b0, 5'd10);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({load_err, load_busy} !== {(c == 4), 1'b1}) begin
        errors++;
        $display("FAIL timeout_cycle%0d: err=%b busy=%b, expected err=%b busy=1", c, load_err, load_busy, c == 4);
      end
      tick();
    end
    checks++;
    if ({load_err, ex_ready, rf_we} !== 3'b010) begin
      errors++;
      $display("FAIL timeout_after: err=%b ready=%b we=%b, expected 0 1 0", load_err, ex_ready, rf_we);
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hAAAA_AAAA;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if (rf_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout_late_drop: we=%b, expected 0", rf_we);
    end
    issue_load(32'h0000_6000, 2'b00, 1'b1, 5'd11);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_00F0;
    tick();
    dmem_rvalid = 1'b0;
    checks++;
    if ({rf_we, rf_rd_addr, rf_wr_data} !== {1'b1, 5'd11, 32'h0000_00F0}) begin
      errors++;
      $display("FAIL timeout_next_load: we=%b addr=%0d data=%h, expected 1 11 000000f0", rf_we, rf_rd_addr, rf_wr_data);
    end
  endtask

  task automatic test_flush_same_and_reset();
    ex_valid = 1'b1; wb_sel = 3'b010; pc_plus4 = 32'h104; rd_addr = 5'd1; rf_we_i = 1'b1; flush = 1'b1;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    checks++;
    if ({rf_we, rf_rd_addr, rf_wr_data, ex_ready} !== {1'b0, 5'd11, 32'h0000_00F0, 1'b1}) begin
      errors++;
      $display("FAIL jal_flush: we=%b addr=%0d data=%h ready=%b, expected 0 11 000000f0 1",
               rf_we, rf_rd_addr, rf_wr_data, ex_ready);
    end
    issue_load(32'h0000_7000, 2'b10, 1'b0, 5'd12);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_ready, load_busy, rf_we, rf_rd_addr, rf_wr_data, load_err} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_in_wait: ready=%b busy=%b we=%b addr=%0d data=%h err=%b, expected ready=1 rest 0",
               ex_ready, load_busy, rf_we, rf_rd_addr, rf_wr_data, load_err);
    end
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; flush = 1'b0; alu_result = '0; pc_plus4 = '0; imm = '0;
    csr_data = '0; wb_sel = '0; rd_addr = '0; rf_we_i = 1'b0; load_size = '0;
    load_unsigned = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_alu();
    test_load_byte();
    test_load_half_word();
    test_flush_load();
    test_timeout();
    test_flush_same_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
